// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU issue/write-back scheduler.
// Unit latencies here must match the attached arithmetic units.
package fpu_pkg;
  localparam int NUM_UNITS  = 8;
  localparam int DATA_W     = 32;
  localparam int TAG_W      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_LAT    = 16;
  localparam int UNIT_W     = $clog2(NUM_UNITS);

  localparam int FADD_U  = 0;
  localparam int FSUB_U  = 1;
  localparam int FMUL_U  = 2;
  localparam int FDIV_U  = 3;
  localparam int FSQRT_U = 4;
  localparam int FTOI_U  = 5;
  localparam int ITOF_U  = 6;
  localparam int FABS_U  = 7;

  localparam int UNIT_LAT [NUM_UNITS] = '{1, 2, 3, 4, 8, 1, 2, 1};

  typedef struct packed {
    logic              valid;
    logic [UNIT_W-1:0] unit;
    logic [TAG_W-1:0]  tag;
  } slot_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } res_t;
endpackage

// File: rtl/fpu_wb_sched_if.sv
// Issue, unit and result signals of the FPU write-back scheduler.
// Handshakes: a transfer happens in a cycle where valid & ready are both high;
// valid never waits on ready, and an issue request may change while ready is low.
interface fpu_wb_sched_if #(
  parameter int NUM_UNITS = 8,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4
);
  logic                        issue_valid;
  logic [NUM_UNITS-1:0]        issue_op;
  logic [TAG_W-1:0]            issue_tag;
  logic                        issue_ready;
  logic [NUM_UNITS-1:0]        unit_start;
  logic [NUM_UNITS-1:0]        unit_valid;
  logic [NUM_UNITS*DATA_W-1:0] unit_y;
  logic                        res_valid;
  logic [DATA_W-1:0]           res_data;
  logic [TAG_W-1:0]            res_tag;
  logic                        res_ready;
  logic                        busy;
  logic                        err;

  modport slave (
    input  issue_valid, issue_op, issue_tag, unit_valid, unit_y, res_ready,
    output issue_ready, unit_start, res_valid, res_data, res_tag, busy, err
  );

  modport master (
    output issue_valid, issue_op, issue_tag, unit_valid, unit_y, res_ready,
    input  issue_ready, unit_start, res_valid, res_data, res_tag, busy, err
  );
endinterface

// File: rtl/fpu_res_fifo.sv
// Synchronous result FIFO with occupancy count; DEPTH must be a power of two.
module fpu_res_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  always_comb begin
    do_pop = pop && (cnt_q != '0);
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;
endmodule

// File: rtl/fpu_wb_sched.sv
// FPU issue/write-back scheduler: reserves a collision-free completion slot per
// accepted op and queues unit results in order of completion.
module fpu_wb_sched #(
  parameter int NUM_UNITS  = fpu_pkg::NUM_UNITS,
  parameter int DATA_W     = fpu_pkg::DATA_W,
  parameter int TAG_W      = fpu_pkg::TAG_W,
  parameter int FIFO_DEPTH = fpu_pkg::FIFO_DEPTH,
  parameter int MAX_LAT    = fpu_pkg::MAX_LAT
) (
  input  logic          sys_clk,
  input  logic          rst,
  fpu_wb_sched_if.slave bus
);
  import fpu_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // sr_q[i] is the op completing i cycles from now; sr_q[0] completes this cycle.
  slot_t                sr_q [MAX_LAT];
  slot_t                sr_d [MAX_LAT];
  slot_t                head;
  logic                 err_q, err_d;
  logic [UNIT_W-1:0]    sel_u;
  logic                 op_onehot, collide, issue_ready, accept, push, pop;
  logic [NUM_UNITS-1:0] exp_mask;
  int                   sel_lat, inflight, credits;
  res_t                 push_ent, head_ent;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 fifo_valid;

  always_comb begin
    op_onehot = (bus.issue_op != '0) &&
                ((bus.issue_op & (bus.issue_op - NUM_UNITS'(1))) == '0);
    sel_u = '0;
    for (int u = 0; u < NUM_UNITS; u++) if (bus.issue_op[u]) sel_u = UNIT_W'(u);
    sel_lat = UNIT_LAT[sel_u];

    collide = 1'b0;
    for (int i = 1; i < MAX_LAT; i++) if (i == sel_lat && sr_q[i].valid) collide = 1'b1;
    inflight = 0;
    for (int i = 0; i < MAX_LAT; i++) if (sr_q[i].valid) inflight++;

    // Credits count this cycle's pop so a full FIFO being drained can still accept.
    pop         = fifo_valid && bus.res_ready;
    credits     = inflight + int'(fifo_cnt) - (pop ? 1 : 0);
    issue_ready = rst && op_onehot && !collide && (credits < FIFO_DEPTH);
    accept      = bus.issue_valid && issue_ready;

    for (int i = 0; i < MAX_LAT - 1; i++) sr_d[i] = sr_q[i + 1];
    sr_d[MAX_LAT-1] = '0;
    if (accept) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        if (i == sel_lat - 1) begin
          sr_d[i].valid = 1'b1;
          sr_d[i].unit  = sel_u;
          sr_d[i].tag   = bus.issue_tag;
        end
      end
    end

    head     = sr_q[0];
    exp_mask = '0;
    if (head.valid) exp_mask[head.unit] = 1'b1;
    push          = head.valid && bus.unit_valid[head.unit];
    push_ent.data = bus.unit_y[int'(head.unit)*DATA_W +: DATA_W];
    push_ent.tag  = head.tag;

    err_d = err_q;
    if (head.valid && !bus.unit_valid[head.unit]) err_d = 1'b1;
    if ((bus.unit_valid & ~exp_mask) != '0) err_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LAT; i++) sr_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      err_q <= err_d;
    end
  end

  fpu_res_fifo #(.W($bits(res_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst_n (rst),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .dout  (head_ent),
    .valid (fifo_valid),
    .count (fifo_cnt)
  );

  assign bus.issue_ready = issue_ready;
  assign bus.unit_start  = accept ? bus.issue_op : '0;
  assign bus.res_valid   = fifo_valid;
  assign bus.res_data    = head_ent.data;
  assign bus.res_tag     = head_ent.tag[TAG_W-1:0];
  assign bus.busy        = (inflight != 0) || fifo_valid;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_fpu_wb_sched.sv
// Directed bench for fpu_wb_sched: behavioural fixed-latency units plus an
// in-order expected-result queue checked at every FIFO pop.
module tb_fpu_wb_sched;
  import fpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  fpu_wb_sched_if #(.NUM_UNITS(NUM_UNITS), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  fpu_wb_sched #(
    .NUM_UNITS(NUM_UNITS), .DATA_W(DATA_W), .TAG_W(TAG_W),
    .FIFO_DEPTH(FIFO_DEPTH), .MAX_LAT(MAX_LAT)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W+TAG_W-1:0] exp_q [$];

  logic [MAX_LAT:0]     line [NUM_UNITS];
  logic [NUM_UNITS-1:0] kill_mask  = '0;
  logic [NUM_UNITS-1:0] force_mask = '0;
  logic [DATA_W-1:0]    y_val [NUM_UNITS];

  logic                 smp_ready, smp_rv, smp_busy, smp_err;
  logic [NUM_UNITS-1:0] smp_start;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- unit models ----------------
  always @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      for (int u = 0; u < NUM_UNITS; u++) line[u] <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++)
        line[u] <= (line[u] >> 1) |
                   ((bus.unit_start[u] ? (MAX_LAT+1)'(1) : (MAX_LAT+1)'(0)) << (UNIT_LAT[u] - 1));
    end
  end

  always_comb begin
    bus.unit_valid = '0;
    bus.unit_y     = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      bus.unit_valid[u] = (line[u][0] & ~kill_mask[u]) | force_mask[u];
      bus.unit_y[u*DATA_W +: DATA_W] = y_val[u];
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge sys_clk) begin
    logic [DATA_W+TAG_W-1:0] e;
    if (rst && bus.res_valid && bus.res_ready) begin
      check_eq("res_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("res_data", 64'(bus.res_data), 64'(e[DATA_W+TAG_W-1:TAG_W]));
        check_eq("res_tag", 64'(bus.res_tag), 64'(e[TAG_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic v, input int u, input logic [TAG_W-1:0] tag);
    bus.issue_valid = v;
    bus.issue_op    = v ? NUM_UNITS'(1) << u : '0;
    bus.issue_tag   = tag;
    @(negedge sys_clk);
    smp_ready = bus.issue_ready;
    smp_start = bus.unit_start;
    smp_rv    = bus.res_valid;
    smp_busy  = bus.busy;
    smp_err   = bus.err;
    @(posedge sys_clk);
    #1;
    bus.issue_valid = 1'b0;
    bus.issue_op    = '0;
  endtask

  task automatic drive_raw(input logic [NUM_UNITS-1:0] op);
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    @(negedge sys_clk);
    smp_ready = bus.issue_ready;
    smp_start = bus.unit_start;
    smp_err   = bus.err;
    @(posedge sys_clk);
    #1;
    bus.issue_valid = 1'b0;
    bus.issue_op    = '0;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 0, '0);
  endtask

  task automatic expect_res(input int u, input logic [TAG_W-1:0] tag);
    exp_q.push_back({y_val[u], tag});
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    bus.res_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      idle();
      n++;
    end
    check_eq({name, "_left"}, 64'(exp_q.size()), 64'd0);
    check_eq({name, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n_acc;
    for (int u = 0; u < NUM_UNITS; u++) y_val[u] = 32'hA000_0000 + 32'(u);
    y_val[2] = 32'h3F80_0000;
    y_val[4] = 32'h4049_0FDB;
    bus.issue_valid = 1'b1;
    bus.issue_op    = 8'b0000_0001;
    bus.issue_tag   = '0;
    bus.res_ready   = 1'b1;

    #2 rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_eq("rst_issue_ready", 64'(bus.issue_ready), 64'd0);
    check_eq("rst_unit_start", 64'(bus.unit_start), 64'd0);
    check_eq("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check_eq("rst_res_data", 64'(bus.res_data), 64'd0);
    check_eq("rst_res_tag", 64'(bus.res_tag), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_err", 64'(bus.err), 64'd0);
    @(posedge sys_clk);
    #1 rst = 1'b1;

    // single op: unit 2 (L=3) tag 5, result visible 4 cycles after issue
    drive_cycle(1'b1, 2, 4'd5);
    check_eq("single_ready", 64'(smp_ready), 64'd1);
    check_eq("single_start", 64'(smp_start), 64'h04);
    expect_res(2, 4'd5);
    repeat (3) idle();
    check_eq("single_rv_early", 64'(smp_rv), 64'd0);
    idle();
    check_eq("single_rv", 64'(smp_rv), 64'd1);
    drain("single", 10);

    // slot collision: unit 3 (L=4) at t, unit 1 (L=2) at t+2 collides, t+3 fits
    drive_cycle(1'b1, 3, 4'd6);
    check_eq("coll_first", 64'(smp_ready), 64'd1);
    expect_res(3, 4'd6);
    idle();
    drive_cycle(1'b1, 1, 4'd7);
    check_eq("coll_ready", 64'(smp_ready), 64'd0);
    check_eq("coll_start", 64'(smp_start), 64'd0);
    drive_cycle(1'b1, 1, 4'd7);
    check_eq("coll_retry", 64'(smp_ready), 64'd1);
    expect_res(1, 4'd7);
    drain("coll", 20);

    // illegal one-hot encodings
    drive_raw('0);
    check_eq("zerohot_ready", 64'(smp_ready), 64'd0);
    drive_raw(8'b0000_0011);
    check_eq("multihot_ready", 64'(smp_ready), 64'd0);
    check_eq("multihot_start", 64'(smp_start), 64'd0);
    check_eq("multihot_err", 64'(smp_err), 64'd0);

    // backpressure: credits cap acceptances at FIFO_DEPTH
    bus.res_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 0, TAG_W'(8 + i));
      if (smp_ready) begin
        n_acc++;
        expect_res(0, TAG_W'(8 + i));
      end
    end
    check_eq("bp_accepted", 64'(n_acc), 64'd4);
    check_eq("bp_ready_low", 64'(smp_ready), 64'd0);
    bus.res_ready = 1'b1;
    drive_cycle(1'b1, 0, 4'd14);
    check_eq("bp_pop_accept", 64'(smp_ready), 64'd1);
    if (smp_ready) expect_res(0, 4'd14);
    drain("bp", 20);

    // out-of-order completion: short op overtakes long op
    drive_cycle(1'b1, 4, 4'd1);
    check_eq("ooo_long", 64'(smp_ready), 64'd1);
    drive_cycle(1'b1, 0, 4'd2);
    check_eq("ooo_short", 64'(smp_ready), 64'd1);
    expect_res(0, 4'd2);
    expect_res(4, 4'd1);
    drain("ooo", 20);

    // missing result: credit released, nothing queued, err set
    kill_mask[2] = 1'b1;
    drive_cycle(1'b1, 2, 4'd3);
    check_eq("miss_ready", 64'(smp_ready), 64'd1);
    repeat (3) idle();
    check_eq("miss_err_pre", 64'(smp_err), 64'd0);
    idle();
    check_eq("miss_err", 64'(smp_err), 64'd1);
    check_eq("miss_busy", 64'(smp_busy), 64'd0);
    check_eq("miss_rv", 64'(smp_rv), 64'd0);
    kill_mask = '0;

    // async reset with three ops in flight
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4, TAG_W'(1 + i));
    check_eq("mid_third_ready", 64'(smp_ready), 64'd1);
    bus.issue_valid = 1'b1;
    bus.issue_op    = 8'b0000_0001;
    @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check_eq("mid_issue_ready", 64'(bus.issue_ready), 64'd0);
    check_eq("mid_unit_start", 64'(bus.unit_start), 64'd0);
    check_eq("mid_res_valid", 64'(bus.res_valid), 64'd0);
    check_eq("mid_res_data", 64'(bus.res_data), 64'd0);
    check_eq("mid_busy", 64'(bus.busy), 64'd0);
    check_eq("mid_err", 64'(bus.err), 64'd0);
    @(posedge sys_clk);
    #1 rst = 1'b1;
    bus.issue_valid = 1'b0;
    drive_cycle(1'b1, 0, 4'd9);
    check_eq("post_rst_ready", 64'(smp_ready), 64'd1);
    expect_res(0, 4'd9);
    drain("post_rst", 20);
    check_eq("post_rst_err", 64'(bus.err), 64'd0);

    // unit result with no reservation
    force_mask[5] = 1'b1;
    idle();
    force_mask = '0;
    idle();
    check_eq("orphan_err", 64'(smp_err), 64'd1);
    check_eq("orphan_rv", 64'(smp_rv), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end
endmodule

// File: doc/fpu_wb_sched.md
# fpu_wb_sched

Issue/write-back scheduler for the FPU cluster. Sits between the core's FP issue port and the N arithmetic units (fadd, fsub, fmul, fdiv, fsqrt, ftoi, itof, fabs, …). It accepts one tagged operation per cycle and pulses the selected unit's start. It reserves a collision-free write-back slot from each unit's fixed latency, so at most one result completes per cycle. Completed results are queued in a result FIFO drained through a valid/ready port; this replaces the hard-wired single-unit output select.

## Interface
Parameters:
- NUM_UNITS, 8, number of attached units; one-hot op width.
- DATA_W, 32, result width.
- TAG_W, 4, destination tag width.
- FIFO_DEPTH, 4, result FIFO entries (power of two, ≥2).
- MAX_LAT, 16, largest legal unit latency.

Ports:
- sys_clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  request present.
- issue_op  in  NUM_UNITS  one-hot unit select.
- issue_tag  in  TAG_W  tag returned with the result.
- issue_ready  out  1  request accepted when issue_valid & issue_ready.
- unit_start  out  NUM_UNITS  one-hot start pulse to units (their stage1_valid).
- unit_valid  in  NUM_UNITS  per-unit out_valid.
- unit_y  in  NUM_UNITS*DATA_W  per-unit results; unit u occupies bits [u*DATA_W +: DATA_W].
- res_valid  out  1  FIFO head valid.
- res_data  out  DATA_W  head result.
- res_tag  out  TAG_W  head tag.
- res_ready  in  1  consumer pops head when res_valid & res_ready.
- busy  out  1  any op in flight or FIFO non-empty.
- err  out  1  sticky protocol error.

## Operation
- Per-unit latency L[u] (1..MAX_LAT) comes from the package constant array.
- Reservation shift register, MAX_LAT slots. Each slot holds: valid, unit index, tag. It advances one slot per cycle.
- issue_ready = 1 when all of the following hold:
  - issue_op is exactly one-hot;
  - no accepted op completes at cycle t+L[u];
  - credits < FIFO_DEPTH, where credits = in-flight ops + FIFO occupancy, evaluated including this cycle's pop.
- Otherwise issue_ready = 0.
- unit_start = issue_op when issue_valid & issue_ready, else 0. It is combinational from the issue inputs and the state; operands route to units outside this block.
- Zero-hot or multi-hot issue_op: never accepted, no start, err unchanged. The core must not present it.
- At a slot's completion cycle, unit_y[u] and the slot tag are written into the FIFO when unit_valid[u] = 1.
- Expected completion without unit_valid[u]: nothing is enqueued, the credit is released, and err is set.
- unit_valid[v] high with no matching reservation: ignored, and err is set.
- FIFO push and pop in the same cycle are legal at any occupancy. Full + push cannot occur because of the credit rule.
- err clears only on reset.

## Timing
- Issue accepted in cycle t → unit_start high in cycle t → unit_valid expected in cycle t+L[u] → FIFO write at the end of that cycle → res_valid at t+L[u]+1 at the earliest (registered FIFO output).
- Throughput: one issue and one pop per cycle.
- Reset (rst = 0, async) values:
  - issue_ready = 0, unit_start = 0, res_valid = 0, res_data = 0, res_tag = 0, busy = 0, err = 0.
  - All reservations and FIFO contents are discarded.
- Reset asserted mid-operation drops in-flight ops. Unit results arriving after release find no reservation; they are ignored and set err. The integrator holds the units in reset together with this block.
- issue_ready becomes 1 in the first cycle after rst deasserts.

## Structure
- Package fpu_pkg holds:
  - UNIT_LAT[NUM_UNITS] latency array;
  - unit index constants FADD_U … FABS_U;
  - a packed struct for a reservation slot {valid, unit index, tag};
  - a packed struct for a result entry {data, tag}.
- Sub-module fpu_res_fifo: parametrised synchronous FIFO with count output, instantiated once.

## Test plan
Tests use UNIT_LAT = {1,2,3,4,8,1,2,1} for units 0..7 and FIFO_DEPTH = 4.
- Single op: issue unit 2 (L = 3), tag 5, at cycle 10; unit_valid[2] at cycle 13 with y = 0x3F800000 → res_valid at cycle 14 with data 0x3F800000, tag 5.
- Slot collision: issue unit 3 (L = 4) at cycle 0, then unit 1 (L = 2) at cycle 2 → issue_ready = 0 at cycle 2. Re-present unit 1 at cycle 3 → accepted.
- Backpressure: hold res_ready = 0 and issue 6 ops to unit 0 → exactly 4 accepted, then issue_ready = 0. Assert res_ready for 1 cycle → one more issue accepted.
- Out-of-order completion: unit 4 (L = 8) tag 1 at cycle 0, unit 0 (L = 1) tag 2 at cycle 1 → FIFO order is tag 2, then tag 1.
- Missing result: unit 2 issued, unit_valid[2] kept low at the expected cycle → err = 1, no FIFO entry, busy returns to 0.
- Async reset with 3 ops in flight → all outputs 0 immediately. After release, a new issue to unit 0 completes normally.
